fill_mem_responder: RTL and testbench

Fixed-latency, fully pipelined word memory on the responder side of the cache-fill interface. It accepts one request per cycle from the cache fill state machine or a data-cache write-through: a read or a write. Each read is answered exactly LATENCY cycles later with a one-cycle `data_valid` pulse. It sits below both caches as the main-memory model and serves the 8-word block fills issued on a miss.

---
 rtl/fill_mem_responder.sv | 66 ++++++
 tb/tb_fill_mem_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fill_mem_responder.sv
// Fixed-latency, fully pipelined 16-bit word memory answering cache-fill reads.
// Read data is captured at issue and carried through a {valid, data} pipeline.
module fill_mem_responder #(
    parameter int LATENCY    = 4,
    parameter int WORDS_LOG2 = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        pending
);

    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << WORDS_LOG2;

    logic [DATA_W-1:0]     mem [0:DEPTH-1];
    logic [WORDS_LOG2-1:0] word_idx;
    logic [15:0]           unused_addr;
    logic                  rd_issue;
    logic                  wr_issue;

    // Stage 0 holds the word sampled at the issue edge; stage LATENCY is presented.
    logic [LATENCY:0]      vld_p;
    logic [DATA_W-1:0]     data_p [0:LATENCY];

    assign word_idx    = addr[WORDS_LOG2:1];
    assign unused_addr = addr;
    assign rd_issue    = enable & ~wr;
    assign wr_issue    = enable & wr;

    // Array is deliberately not reset so contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (wr_issue && !rst) begin
            mem[word_idx] <= data_in;
        end
    end

    // Data stages carry no reset; validity alone decides what is presented.
    always_ff @(posedge clk) begin
        if (rd_issue) begin
            data_p[0] <= mem[word_idx];
        end
        for (int i = 1; i <= LATENCY; i++) begin
            data_p[i] <= data_p[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p <= {vld_p[LATENCY-1:0], rd_issue};
        end
    end

    // Outputs depend only on registers; the presented stage leaves pending.
    assign data_valid = vld_p[LATENCY];
    assign data_out   = vld_p[LATENCY] ? data_p[LATENCY] : '0;
    assign pending    = |vld_p[LATENCY-1:0];

endmodule

// File: tb/tb_fill_mem_responder.sv
// Scoreboard bench for fill_mem_responder: directed requests push expected
// {return cycle, data}; a negedge monitor pops and compares each data_valid.
module tb_fill_mem_responder;

    localparam int LATENCY    = 4;
    localparam int WORDS_LOG2 = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic        pending;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    fill_mem_responder #(
        .LATENCY   (LATENCY),
        .WORDS_LOG2(WORDS_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .wr        (wr),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor: every presented read must match the oldest expectation, in data and in cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got data_valid=1 data_out=%h expected no read (cycle %0d)",
                             data_out, cyc);
                end else begin
                    e = q.pop_front();
                    chk("rd_data", {16'h0, data_out}, {16'h0, e.data});
                    chk("rd_cycle", cyc, e.cyc);
                end
            end else begin
                chk("idle_data_zero", {16'h0, data_out}, 32'h0);
            end
        end
    end

    task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp);
        enable  = 1'b1;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        if (!w) q.push_back('{cyc + LATENCY, exp});
        enable = 1'b0;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0;
        data_in = 16'h0;
        #3;
        chk("reset_valid", {31'h0, data_valid}, 32'h0);
        chk("reset_data", {16'h0, data_out}, 32'h0);
        chk("reset_pending", {31'h0, pending}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single read with pending window.
        dut.mem[16'h0123] = 16'hBEEF;
        req(1'b0, 16'h0246, 16'h0, 16'hBEEF);
        chk("single_pending_0", {31'h0, pending}, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            idle(1);
            chk("single_pending", {31'h0, pending}, (k < 4) ? 32'h1 : 32'h0);
            chk("single_valid", {31'h0, data_valid}, (k == 4) ? 32'h1 : 32'h0);
        end
        idle(2);

        // Eight-word block fill, word value equals its byte address.
        for (int i = 0; i < 8; i++) dut.mem[(16'h1230 + 16'(2*i)) >> 1] = 16'h1230 + 16'(2*i);
        for (int i = 0; i < 8; i++) req(1'b0, 16'h1230 + 16'(2*i), 16'h0, 16'h1230 + 16'(2*i));
        idle(LATENCY + 2);

        // Write then read; a later write cannot disturb the in-flight read.
        req(1'b1, 16'h0010, 16'hA5A5, 16'h0);
        req(1'b0, 16'h0010, 16'h0, 16'hA5A5);
        req(1'b1, 16'h0010, 16'h1111, 16'h0);
        idle(LATENCY + 1);
        req(1'b0, 16'h0010, 16'h0, 16'h1111);
        idle(LATENCY + 2);

        // Read then write to the same address.
        dut.mem[16'h0010] = 16'h0007;
        req(1'b0, 16'h0020, 16'h0, 16'h0007);
        req(1'b1, 16'h0020, 16'hFFFF, 16'h0);
        req(1'b0, 16'h0020, 16'h0, 16'hFFFF);
        idle(LATENCY + 2);

        // Odd address aliases the even one; two bubbles put the pulses 3 cycles apart.
        dut.mem[16'h0010] = 16'h3C5A;
        req(1'b0, 16'h0021, 16'h0, 16'h3C5A);
        idle(2);
        req(1'b0, 16'h0020, 16'h0, 16'h3C5A);
        idle(LATENCY + 2);

        // Asynchronous reset with three reads in flight.
        req(1'b1, 16'h0100, 16'h5555, 16'h0);
        req(1'b0, 16'h0100, 16'h0, 16'h5555);
        req(1'b0, 16'h0100, 16'h0, 16'h5555);
        req(1'b0, 16'h0100, 16'h0, 16'h5555);
        chk("pre_reset_pending", {31'h0, pending}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", {31'h0, data_valid}, 32'h0);
        chk("async_data", {16'h0, data_out}, 32'h0);
        chk("async_pending", {31'h0, pending}, 32'h0);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(10);
        req(1'b0, 16'h0100, 16'h0, 16'h5555);
        idle(LATENCY + 2);

        chk("drained", q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
